// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg                                                             |
// | Shared UART types, LCR field positions and oversampling constants.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int LCR_WLS = 0;   // 2-bit word length field starts here
    localparam int LCR_STB = 2;
    localparam int LCR_PEN = 3;
    localparam int LCR_EPS = 4;
    localparam int LCR_SP  = 5;

    localparam int         OVERSAMPLE  = 16;
    localparam logic [3:0] MID_SAMPLE  = 4'd7;
    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

    // Index of the final data bit for a given word-length code.
    function automatic logic [2:0] last_bit(input logic [1:0] wls);
        return 3'd4 + {1'b0, wls};
    endfunction

    function automatic logic expected_parity(input logic [7:0] data,
                                             input logic       even,
                                             input logic       stick);
        if (stick)
            return ~even;
        return even ? (^data) : (~^data);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_baud_gen                                                        |
// | Divisor counter producing a one-clock 16x oversample tick.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_baud_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] divisor,
    output logic        tick
);

    logic [15:0] r_div;
    logic [15:0] r_cnt;
    logic        w_wrap;

    assign w_wrap = (r_div != 16'd0) && (r_cnt == r_div - 16'd1);
    assign tick   = w_wrap;

    // The divisor is only resampled at a wrap (or while stopped), so a
    // rewrite never produces a short or stretched tick period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= 16'd0;
            r_cnt <= 16'd0;
        end else if ((r_div == 16'd0) || w_wrap) begin
            r_div <= divisor;
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_core                                                         |
// | UART receiver: sync, 16x oversampled deframer, one-entry holding reg.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [7:0] lcr,
    input  logic [7:0] dll,
    input  logic [7:0] dlh,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       pe,
    output logic       fe,
    output logic       bi,
    output logic       oe,
    output logic       rx_busy
);

    localparam int c_stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [c_stages-1:0] r_sync;
    logic                w_rs;
    logic [15:0]         w_divisor;
    logic                w_run;
    logic                w_tick_raw;
    logic                w_tick;

    uart_state_e r_state;
    logic [3:0]  r_sc;
    logic [2:0]  r_bc;
    logic [7:0]  r_shift;
    logic        r_par_bit;
    logic [1:0]  r_wls;
    logic        r_pen;
    logic        r_eps;
    logic        r_sp;
    logic        r_armed;

    logic        w_last_sample;
    logic        w_load;
    logic        w_pe;
    logic        w_fe;
    logic        w_bi;
    logic        w_unused_lcr;

    assign w_unused_lcr = &{1'b0, lcr[7:6], lcr[LCR_STB]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sync <= '1;
        else
            r_sync <= {r_sync[c_stages-2:0], rx};
    end

    assign w_rs      = r_sync[c_stages-1];
    assign w_divisor = {dlh, dll};
    assign w_run     = (w_divisor != 16'd0);

    uart_baud_gen u_baud (
        .clk     (clk),
        .rst     (rst),
        .divisor (w_divisor),
        .tick    (w_tick_raw)
    );

    // The baud counter may still fire once after D is cleared; gate it here.
    assign w_tick        = w_tick_raw & w_run;
    assign w_last_sample = w_tick && (r_sc == LAST_SAMPLE);
    assign w_load        = w_last_sample && (r_state == ST_STOP);

    assign w_fe = ~w_rs;
    assign w_pe = r_pen && (r_par_bit != expected_parity(r_shift, r_eps, r_sp));
    assign w_bi = (r_shift == 8'd0) && (~r_pen || ~r_par_bit) && ~w_rs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sc      <= 4'd0;
            r_bc      <= 3'd0;
            r_shift   <= 8'd0;
            r_par_bit <= 1'b0;
            r_wls     <= 2'd0;
            r_pen     <= 1'b0;
            r_eps     <= 1'b0;
            r_sp      <= 1'b0;
            r_armed   <= 1'b1;
        end else if (!w_run) begin
            r_state <= ST_IDLE;
            r_sc    <= 4'd0;
            r_bc    <= 3'd0;
        end else if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    // After a break the line must be seen high before re-arming.
                    if (!r_armed) begin
                        if (w_rs)
                            r_armed <= 1'b1;
                    end else if (!w_rs) begin
                        r_state <= ST_START;
                        r_sc    <= 4'd0;
                    end
                end
                ST_START: begin
                    if (r_sc == MID_SAMPLE) begin
                        if (w_rs) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_DATA;
                            r_sc      <= 4'd0;
                            r_bc      <= 3'd0;
                            r_shift   <= 8'd0;
                            r_par_bit <= 1'b0;
                            r_wls     <= lcr[LCR_WLS +: 2];
                            r_pen     <= lcr[LCR_PEN];
                            r_eps     <= lcr[LCR_EPS];
                            r_sp      <= lcr[LCR_SP];
                        end
                    end else begin
                        r_sc <= r_sc + 4'd1;
                    end
                end
                ST_DATA: begin
                    r_sc <= r_sc + 4'd1;
                    if (r_sc == LAST_SAMPLE) begin
                        r_shift[r_bc] <= w_rs;
                        r_bc          <= r_bc + 3'd1;
                        if (r_bc == last_bit(r_wls))
                            r_state <= r_pen ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    r_sc <= r_sc + 4'd1;
                    if (r_sc == LAST_SAMPLE) begin
                        r_par_bit <= w_rs;
                        r_state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    r_sc <= r_sc + 4'd1;
                    if (r_sc == LAST_SAMPLE) begin
                        r_state <= ST_IDLE;
                        if (w_bi)
                            r_armed <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Holding register: a load in the same cycle as a pop replaces the
    // character cleanly; a load onto an unread character flags overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data  <= 8'd0;
            rx_ready <= 1'b0;
            pe       <= 1'b0;
            fe       <= 1'b0;
            bi       <= 1'b0;
            oe       <= 1'b0;
        end else if (w_load) begin
            rx_data  <= r_shift;
            rx_ready <= 1'b1;
            pe       <= w_pe;
            fe       <= w_fe;
            bi       <= w_bi;
            if (rx_ready && !rd)
                oe <= 1'b1;
            else if (rx_ready && rd)
                oe <= 1'b0;
        end else if (rd && rx_ready) begin
            rx_ready <= 1'b0;
            pe       <= 1'b0;
            fe       <= 1'b0;
            bi       <= 1'b0;
            oe       <= 1'b0;
        end
    end

    assign rx_busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_uart_rx_core                                                      |
// | Vector table, randomized frames vs. reference model, corner cases.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rd  = 1'b0;
    logic [7:0] lcr = 8'h03;
    logic [7:0] dll = 8'd2;
    logic [7:0] dlh = 8'd0;
    logic [7:0] rx_data;
    logic       rx_ready, pe, fe, bi, oe, rx_busy;

    int errors   = 0;
    int checks   = 0;
    int bit_clks = 32;
    logic mon_en    = 1'b0;
    logic busy_seen = 1'b0;

    uart_rx_core #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .rx(rx), .lcr(lcr), .dll(dll), .dlh(dlh),
        .rd(rd), .rx_data(rx_data), .rx_ready(rx_ready), .pe(pe), .fe(fe),
        .bi(bi), .oe(oe), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mon_en && rx_busy)
            busy_seen <= 1'b1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] l;
        logic [7:0] d;
        logic       p;
        logic       s;
        logic [7:0] ed;
        logic       epe;
        logic       efe;
        logic       ebi;
    } vec_t;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_div(input int d);
        dll = d[7:0];
        dlh = d[15:8];
        bit_clks = 16 * d;
        repeat (80) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] l, input logic [7:0] d,
                              input logic p, input logic s);
        int n;
        n = 5 + int'(l[1:0]);
        lcr = l;
        drive(1'b0, bit_clks);
        for (int i = 0; i < n; i++)
            drive(d[i], bit_clks);
        if (l[3])
            drive(p, bit_clks);
        drive(s, bit_clks);
        drive(1'b1, bit_clks);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check1({name, " rx_ready"}, rx_ready, 1'b1);
    endtask

    task automatic pop();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    // Reference: the received character from the frame-level rules.
    function automatic vec_t model(input logic [7:0] l, input logic [7:0] d,
                                   input logic p, input logic s);
        vec_t r;
        int   n;
        int   ones;
        logic want;
        n    = 5 + int'(l[1:0]);
        r.l  = l; r.d = d; r.p = p; r.s = s;
        r.ed = d & 8'((1 << n) - 1);
        ones = $countones(r.ed);
        if (l[5])
            want = !l[4];
        else if (l[4])
            want = (ones % 2) == 1;
        else
            want = (ones % 2) == 0;
        r.epe = l[3] && (p != want);
        r.efe = !s;
        r.ebi = (r.ed == 8'd0) && (!l[3] || !p) && !s;
        return r;
    endfunction

    task automatic check_char(input string name, input vec_t v);
        wait_ready(name);
        check8({name, " rx_data"}, rx_data, v.ed);
        check1({name, " pe"}, pe, v.epe);
        check1({name, " fe"}, fe, v.efe);
        check1({name, " bi"}, bi, v.ebi);
        check1({name, " oe"}, oe, 1'b0);
        pop();
        check1({name, " rx_ready after rd"}, rx_ready, 1'b0);
        check1({name, " pe after rd"}, pe, 1'b0);
        check8({name, " rx_data held"}, rx_data, v.ed);
    endtask

    vec_t vt[9];
    vec_t mv;
    logic [31:0] rv;
    logic [7:0]  rl, rdat;

    initial begin
        vt[0] = '{8'h03, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
        vt[1] = '{8'h0B, 8'hA3, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0};
        vt[2] = '{8'h0B, 8'hA3, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0};
        vt[3] = '{8'h2B, 8'hA3, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0};
        vt[4] = '{8'h3B, 8'hA3, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0};
        vt[5] = '{8'h00, 8'h1F, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b0};
        vt[6] = '{8'h03, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
        vt[7] = '{8'h01, 8'hFF, 1'b0, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0};
        vt[8] = '{8'h1B, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};

        repeat (4) @(negedge clk);
        check8("reset rx_data", rx_data, 8'h00);
        check1("reset rx_ready", rx_ready, 1'b0);
        check1("reset oe", oe, 1'b0);
        check1("reset rx_busy", rx_busy, 1'b0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            send_frame(vt[i].l, vt[i].d, vt[i].p, vt[i].s);
            check_char($sformatf("vec%0d", i), vt[i]);
        end

        // Line held low for two frame times: one break character only.
        lcr = 8'h03;
        drive(1'b0, 20 * bit_clks);
        check1("break rx_busy while low", rx_busy, 1'b0);
        check1("break rx_ready", rx_ready, 1'b1);
        check8("break rx_data", rx_data, 8'h00);
        check1("break fe", fe, 1'b1);
        check1("break bi", bi, 1'b1);
        check1("break oe", oe, 1'b0);
        drive(1'b1, 2 * bit_clks);
        check1("break oe after high", oe, 1'b0);
        pop();
        send_frame(8'h03, 8'h5A, 1'b0, 1'b1);
        check_char("after break", model(8'h03, 8'h5A, 1'b0, 1'b1));

        // Overrun.
        send_frame(8'h03, 8'h11, 1'b0, 1'b1);
        send_frame(8'h03, 8'h22, 1'b0, 1'b1);
        wait_ready("overrun");
        check8("overrun rx_data", rx_data, 8'h22);
        check1("overrun oe", oe, 1'b1);
        pop();
        check1("overrun oe after rd", oe, 1'b0);
        check1("overrun rx_ready after rd", rx_ready, 1'b0);

        // Short glitch is rejected as a false start.
        drive(1'b0, 4);
        drive(1'b1, 100);
        check1("glitch rx_busy", rx_busy, 1'b0);
        check1("glitch rx_ready", rx_ready, 1'b0);

        // Randomized frames against the reference model.
        for (int k = 0; k < 24; k++) begin
            rv = $urandom;
            set_div(1 + int'(rv[9:8] % 3));
            rl   = {2'b00, rv[5:0]};
            rdat = rv[23:16];
            mv   = model(rl, rdat, rv[6], rv[12:10] != 3'd0);
            send_frame(rl, rdat, rv[6], rv[12:10] != 3'd0);
            check_char($sformatf("rand%0d lcr=%h d=%h", k, rl, rdat), mv);
        end
        set_div(2);

        // Asynchronous reset in the middle of a data bit.
        send_frame(8'h03, 8'h81, 1'b0, 1'b1);
        wait_ready("pre-reset");
        drive(1'b0, bit_clks);
        drive(1'b1, 2 * bit_clks);
        check1("pre-reset rx_busy", rx_busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check1("mid-frame reset rx_busy", rx_busy, 1'b0);
        check1("mid-frame reset rx_ready", rx_ready, 1'b0);
        check8("mid-frame reset rx_data", rx_data, 8'h00);
        check1("mid-frame reset oe", oe, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 64);

        // Divisor zero: the line toggles but no frame starts.
        dll = 8'd0;
        dlh = 8'd0;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;
        for (int t = 0; t < 60; t++) begin
            rv = $urandom;
            drive(rv[0], 1 + int'(rv[3:1]));
        end
        drive(1'b1, 4);
        mon_en = 1'b0;
        check1("div0 rx_busy seen", busy_seen, 1'b0);
        check1("div0 rx_ready", rx_ready, 1'b0);
        set_div(2);
        send_frame(8'h03, 8'hC6, 1'b0, 1'b1);
        check_char("after div0", model(8'h03, 8'hC6, 1'b0, 1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
